// File: rtl/conv_mac_array.sv
// Multichannel MAC array: accumulates TAPS beats of IN_CH samples into OUT_CH dot products.
// Latency: dout is registered on the edge that accepts the last beat of a frame.
// Backpressure: din_ready is high only while accumulating; dout/out_valid hold until out_ready.
module conv_mac_array #(
  parameter int IN_CH     = 4,
  parameter int OUT_CH    = 4,
  parameter int TAPS      = 16,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 8,
  parameter int OUT_W     = 16,
  parameter int OUT_SHIFT = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              op_st,
  input  logic                              cfg_we,
  input  logic [$clog2(OUT_CH*TAPS)-1:0]    cfg_addr,
  input  logic [COEF_W-1:0]                 cfg_data,
  input  logic                              din_valid,
  output logic                              din_ready,
  input  logic [IN_CH*DATA_W-1:0]           din,
  input  logic                              sat_en,
  output logic [OUT_CH*OUT_W-1:0]           dout,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              busy,
  output logic                              done
);

  localparam int NCOEF = OUT_CH * TAPS;
  localparam int ACC_W = DATA_W + COEF_W + $clog2(IN_CH * TAPS);
  localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);
  // Signed OUT_W range expressed at accumulator width for clamping.
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

  state_t                  state;
  logic [COEF_W-1:0]       coef    [NCOEF];
  logic signed [ACC_W-1:0] acc     [OUT_CH];
  logic signed [ACC_W-1:0] acc_nxt [OUT_CH];
  logic signed [ACC_W-1:0] samp_ext;
  logic signed [ACC_W-1:0] coef_ext;
  logic signed [ACC_W-1:0] shifted;
  logic [OUT_CH*OUT_W-1:0] dout_nxt;
  logic [TAP_W-1:0]        tap;
  logic                    beat;

  assign beat = din_valid & din_ready;
  // Completion is flagged exactly on the cycle the result is handed off.
  assign done = out_valid & out_ready;

  // Accumulator values after folding in the current beat's per-channel dot product.
  always_comb begin
    samp_ext = '0;
    coef_ext = '0;
    for (int o = 0; o < OUT_CH; o++) begin
      acc_nxt[o] = acc[o];
      for (int i = 0; i < IN_CH; i++) begin
        samp_ext = {{(ACC_W-DATA_W){din[i*DATA_W+DATA_W-1]}}, din[i*DATA_W +: DATA_W]};
        coef_ext = {{(ACC_W-COEF_W){coef[o*TAPS + int'(tap)][COEF_W-1]}},
                    coef[o*TAPS + int'(tap)]};
        acc_nxt[o] = acc_nxt[o] + samp_ext * coef_ext;
      end
    end
  end

  // Scale, then clamp or wrap each channel into its output field (channel 0 in the MSBs).
  always_comb begin
    dout_nxt = '0;
    shifted  = '0;
    for (int o = 0; o < OUT_CH; o++) begin
      shifted = acc_nxt[o] >>> OUT_SHIFT;
      if (sat_en && (shifted > OUT_MAX)) begin
        dout_nxt[(OUT_CH-1-o)*OUT_W +: OUT_W] = OUT_MAX[OUT_W-1:0];
      end else if (sat_en && (shifted < OUT_MIN)) begin
        dout_nxt[(OUT_CH-1-o)*OUT_W +: OUT_W] = OUT_MIN[OUT_W-1:0];
      end else begin
        dout_nxt[(OUT_CH-1-o)*OUT_W +: OUT_W] = shifted[OUT_W-1:0];
      end
    end
  end

  // Coefficient store: reset to a ramp, writable only between frames.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NCOEF; k++) begin
        coef[k] <= COEF_W'(k + 1);
      end
    end else if ((state == IDLE) && cfg_we && (int'(cfg_addr) < NCOEF)) begin
      coef[cfg_addr] <= cfg_data;
    end
  end

  // Frame control: start, beat accumulation, and held result until handoff.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      tap       <= '0;
      dout      <= '0;
      out_valid <= 1'b0;
      din_ready <= 1'b0;
      busy      <= 1'b0;
      for (int o = 0; o < OUT_CH; o++) begin
        acc[o] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (op_st) begin
            for (int o = 0; o < OUT_CH; o++) begin
              acc[o] <= '0;
            end
            tap       <= '0;
            din_ready <= 1'b1;
            busy      <= 1'b1;
            state     <= ACCUM;
          end
        end
        ACCUM: begin
          if (beat) begin
            for (int o = 0; o < OUT_CH; o++) begin
              acc[o] <= acc_nxt[o];
            end
            if (tap == LAST_TAP) begin
              dout      <= dout_nxt;
              out_valid <= 1'b1;
              din_ready <= 1'b0;
              state     <= OUTPUT;
            end else begin
              tap <= tap + 1'b1;
            end
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          din_ready <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_mac_array.sv
// Directed bench for conv_mac_array with hand-computed frame results.
// Drives inputs 1ns after the rising edge and samples outputs at the same point.
// Every result is compared against constants derived from the coefficient ramp.
module tb_conv_mac_array;

  localparam int IN_CH  = 4;
  localparam int OUT_CH = 4;
  localparam int TAPS   = 16;
  localparam int DATA_W = 16;
  localparam int COEF_W = 8;
  localparam int OUT_W  = 16;
  localparam int AW     = $clog2(OUT_CH*TAPS);

  // Ramp coefficients, din all +1: (1024*o+544)>>>4 = 34, 98, 162, 226.
  localparam logic [63:0] EXP_ONES  = 64'h0022_0062_00A2_00E2;
  // din all -1: negated fields.
  localparam logic [63:0] EXP_MINUS = 64'hFFDE_FF9E_FF5E_FF1E;
  // Coefs 127, din 0x7FFF: acc = 64*127*32767, >>>4 = 0xFDFE04.
  localparam logic [63:0] EXP_SAT   = 64'h7FFF_7FFF_7FFF_7FFF;
  localparam logic [63:0] EXP_WRAP  = 64'hFE04_FE04_FE04_FE04;

  logic                     clk;
  logic                     rst;
  logic                     op_st;
  logic                     cfg_we;
  logic [AW-1:0]            cfg_addr;
  logic [COEF_W-1:0]        cfg_data;
  logic                     din_valid;
  logic                     din_ready;
  logic [IN_CH*DATA_W-1:0]  din;
  logic                     sat_en;
  logic [OUT_CH*OUT_W-1:0]  dout;
  logic                     out_valid;
  logic                     out_ready;
  logic                     busy;
  logic                     done;

  int total;
  int bad;

  conv_mac_array dut (
    .clk       (clk),
    .rst       (rst),
    .op_st     (op_st),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .din       (din),
    .sat_en    (sat_en),
    .dout      (dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    op_st = 1'b1;
    tick();
    op_st = 1'b0;
  endtask

  // Sixteen beats of a constant sample; gap>0 inserts idle cycles before some beats.
  task automatic send_beats(input logic [15:0] v, input int gap);
    for (int t = 0; t < TAPS; t++) begin
      if (gap > 0 && (t % 3) == 1) begin
        din_valid = 1'b0;
        din       = {4{16'h1234}};
        repeat (gap) tick();
      end
      din       = {4{v}};
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd1);
  endtask

  task automatic finish_frame(input string tag, input logic [63:0] exp);
    wait_out(tag);
    check({tag, "_dout"}, dout, exp);
    check({tag, "_busy"}, {63'd0, busy}, 64'd1);
    check({tag, "_din_ready"}, {63'd0, din_ready}, 64'd0);
    out_ready = 1'b1;
    #1;
    check({tag, "_done"}, {63'd0, done}, 64'd1);
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_after"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_busy_after"}, {63'd0, busy}, 64'd0);
    check({tag, "_done_after"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    op_st     = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    din_valid = 1'b0;
    din       = '0;
    sat_en    = 1'b1;
    out_ready = 1'b0;
    repeat (3) tick();

    // Reset state.
    check("rst_dout", dout, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_din_ready", {63'd0, din_ready}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    rst = 1'b1;
    tick();

    // Beats offered in IDLE must be ignored, then a frame of +1.
    din       = {4{16'h0005}};
    din_valid = 1'b1;
    repeat (2) tick();
    din_valid = 1'b0;
    check("idle_din_ready", {63'd0, din_ready}, 64'd0);
    start_frame();
    check("start_busy", {63'd0, busy}, 64'd1);
    check("start_din_ready", {63'd0, din_ready}, 64'd1);
    send_beats(16'h0001, 0);
    finish_frame("ones", EXP_ONES);

    // Frame of -1.
    start_frame();
    send_beats(16'hFFFF, 0);
    finish_frame("minus", EXP_MINUS);

    // Valid gaps must not change the result.
    start_frame();
    send_beats(16'h0001, 2);
    finish_frame("gaps", EXP_ONES);

    // Stall in OUTPUT with op_st, cfg_we and din_valid all active.
    start_frame();
    send_beats(16'h0001, 0);
    wait_out("hold");
    for (int c = 0; c < 5; c++) begin
      op_st     = 1'b1;
      cfg_we    = 1'b1;
      cfg_addr  = '0;
      cfg_data  = '0;
      din_valid = 1'b1;
      tick();
      check("hold_dout", dout, EXP_ONES);
      check("hold_out_valid", {63'd0, out_valid}, 64'd1);
      check("hold_din_ready", {63'd0, din_ready}, 64'd0);
    end
    op_st     = 1'b0;
    cfg_we    = 1'b0;
    din_valid = 1'b0;
    finish_frame("hold", EXP_ONES);
    // The write attempted during OUTPUT must not have landed.
    start_frame();
    send_beats(16'h0001, 0);
    finish_frame("after_hold", EXP_ONES);

    // Reset mid-frame after 7 beats.
    start_frame();
    din       = {4{16'h0001}};
    din_valid = 1'b1;
    repeat (7) tick();
    din_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_din_ready", {63'd0, din_ready}, 64'd0);
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    tick();
    rst = 1'b1;
    tick();
    check("midrst_no_output", {63'd0, out_valid}, 64'd0);
    check("midrst_dout", dout, 64'd0);
    start_frame();
    send_beats(16'h0001, 0);
    finish_frame("post_rst", EXP_ONES);

    // All coefficients to 127; the last write coincides with op_st.
    for (int k = 0; k < OUT_CH*TAPS; k++) begin
      cfg_we   = 1'b1;
      cfg_addr = AW'(k);
      cfg_data = 8'd127;
      op_st    = (k == OUT_CH*TAPS-1);
      tick();
    end
    cfg_we = 1'b0;
    op_st  = 1'b0;
    sat_en = 1'b1;
    send_beats(16'h7FFF, 0);
    finish_frame("sat", EXP_SAT);

    sat_en = 1'b0;
    start_frame();
    send_beats(16'h7FFF, 0);
    finish_frame("wrap", EXP_WRAP);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_mac_array.md
CONV_MAC_ARRAY -- requirements
Module: conv_mac_array

Interface
REQ-001 The module SHALL have parameter IN_CH, 4, number of input channels per beat.
REQ-002 The module SHALL have parameter OUT_CH, 4, number of output channels.
REQ-003 The module SHALL have parameter TAPS, 16, number of beats per frame.
REQ-004 The module SHALL have parameter DATA_W, 16, signed input sample width.
REQ-005 The module SHALL have parameter COEF_W, 8, signed coefficient width.
REQ-006 The module SHALL have parameter OUT_W, 16, per-channel output field width.
REQ-007 The module SHALL have parameter OUT_SHIFT, 4, arithmetic right shift applied to each accumulator before output.
REQ-008 The module SHALL have a single clock domain and an asynchronous, active-low reset, with ports named as follows.
REQ-009 The module SHALL have the following ports, in this order:
  clk       input   1                           clock, rising edge
  rst       input   1                           asynchronous reset, active-low
  op_st     input   1                           start-frame request
  cfg_we    input   1                           coefficient write strobe
  cfg_addr  input   clog2(OUT_CH*TAPS)          coefficient index, o*TAPS+t
  cfg_data  input   COEF_W                      signed coefficient
  din_valid input   1                           input beat valid
  din_ready output  1                           input beat accepted when high with din_valid
  din       input   IN_CH*DATA_W                channel i at bits [i*DATA_W +: DATA_W]
  sat_en    input   1                           1 = saturate, 0 = wrap
  dout      output  OUT_CH*OUT_W                channel 0 in the MSBs, channel OUT_CH-1 in the LSBs
  out_valid output  1                           dout valid
  out_ready input   1                           downstream accepts dout
  busy      output  1                           high in any state except IDLE
  done      output  1                           one-cycle pulse on the output handshake

Function
REQ-010 The module SHALL use an FSM with states IDLE, ACCUM and OUTPUT.
REQ-011 In IDLE, op_st=1 SHALL clear all accumulators and the tap counter and move the FSM to ACCUM on the next cycle.
REQ-012 op_st SHALL be ignored in ACCUM and OUTPUT.
REQ-013 din_ready SHALL equal 1 only in ACCUM; beats presented in other states SHALL be ignored.
REQ-014 On each accepted beat t (0..TAPS-1), every output channel o SHALL update acc[o] += sum over i of din[i]*coef[o][t], with fully signed arithmetic.
REQ-015 Each accumulator SHALL be DATA_W+COEF_W+clog2(IN_CH*TAPS) bits wide so that it never overflows.
REQ-016 The tap counter SHALL advance only on an accepted beat; a gap in din_valid SHALL stall it and leave the accumulators unchanged.
REQ-017 After the TAPS-th accepted beat, the FSM SHALL enter OUTPUT on the next cycle with dout registered and out_valid=1.
REQ-018 Each output field SHALL be computed as acc>>>OUT_SHIFT, then clamped to the signed OUT_W range if sat_en=1, or its low OUT_W bits taken if sat_en=0.
REQ-019 sat_en SHALL be sampled on the cycle dout is registered.
REQ-020 In OUTPUT, dout and out_valid SHALL stay stable until out_ready=1.
REQ-021 The out_valid and out_ready handshake SHALL pulse done for one cycle and return the FSM to IDLE on the next cycle.
REQ-022 cfg_we SHALL write coefficient RAM entry cfg_addr only in IDLE; writes in other states SHALL be ignored.
REQ-023 When cfg_we and op_st are both high in IDLE, the write SHALL commit and be used by the frame that starts.
REQ-024 cfg_addr values greater than or equal to OUT_CH*TAPS SHALL be ignored.

Reset
REQ-025 While rst=0, the FSM SHALL be in IDLE, and accumulators, tap counter, dout, out_valid, din_ready, busy and done SHALL all be 0.
REQ-026 Reset SHALL load coefficient coef[o][t] = o*TAPS+t+1, truncated to COEF_W.
REQ-027 Reset asserted mid-frame SHALL abandon the frame, and no output SHALL be produced for it.

Verification
REQ-028 Reset, then op_st, then 16 beats of din all 1: dout = {16'd34, 16'd98, 16'd162, 16'd226}, out_valid=1, done pulses once on the handshake.
REQ-029 Same frame with din all -1: channel 0 = 16'hFFDE (-34).
REQ-030 Load all coefficients to 127 and send din all 16'h7FFF: every field = 16'h7FFF with sat_en=1, and 16'hFE04 with sat_en=0.
REQ-031 Hold out_ready=0 for 5 cycles in OUTPUT: dout stays stable, din_ready=0, op_st and cfg_we are ignored; then out_ready=1 gives done and a return to IDLE.
REQ-032 Insert din_valid gaps between beats: the result is identical to REQ-028.
REQ-033 Assert rst=0 after 7 beats, release it, run the REQ-028 frame: the result matches REQ-028 with no stale output.
